// File: rtl/tri_mem_fetcher_pkg.sv
// Shared types and constants for the triangle record fetcher: FSM states,
// record word slots and the helpers that map a word slot onto a vertex lane.
package tri_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  localparam int WORDS_PER_TRI = 10;
  localparam int WORD_W        = 32;
  localparam int WORD_IDX_W    = 4;
  localparam int VERTEX_W      = 3 * WORD_W;

  localparam logic [WORD_IDX_W-1:0] V0_X  = 4'd0;
  localparam logic [WORD_IDX_W-1:0] V0_Y  = 4'd1;
  localparam logic [WORD_IDX_W-1:0] V0_Z  = 4'd2;
  localparam logic [WORD_IDX_W-1:0] V1_X  = 4'd3;
  localparam logic [WORD_IDX_W-1:0] V1_Y  = 4'd4;
  localparam logic [WORD_IDX_W-1:0] V1_Z  = 4'd5;
  localparam logic [WORD_IDX_W-1:0] V2_X  = 4'd6;
  localparam logic [WORD_IDX_W-1:0] V2_Y  = 4'd7;
  localparam logic [WORD_IDX_W-1:0] V2_Z  = 4'd8;
  localparam logic [WORD_IDX_W-1:0] SID_W = 4'd9;

  // Which output a slot belongs to: 0..2 are vertices, 3 is the shader id.
  function automatic logic [1:0] slot_vertex(input logic [WORD_IDX_W-1:0] slot);
    if (slot <= V0_Z) return 2'd0;
    if (slot <= V1_Z) return 2'd1;
    if (slot <= V2_Z) return 2'd2;
    return 2'd3;
  endfunction

  function automatic int unsigned slot_lsb(input logic [WORD_IDX_W-1:0] slot);
    case (slot)
      V0_Y, V1_Y, V2_Y: return WORD_W;
      V0_Z, V1_Z, V2_Z: return 2 * WORD_W;
      default:          return 0;
    endcase
  endfunction

endpackage

// File: rtl/tri_mem_fetcher_if.sv
// Single-outstanding scene-memory read port used by the triangle fetcher.
interface tri_mem_fetcher_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_gnt;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_gnt,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_gnt,
    output mem_rdata,
    output mem_rvalid
  );

endinterface

// File: rtl/tri_mem_fetcher_assembler.sv
// Collects the ten record words into registered v0/v1/v2/sid outputs;
// a synchronous clear zeroes the whole record.
module tri_word_assembler
  import tri_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [WORD_IDX_W-1:0] i_word_idx,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [VERTEX_W-1:0]   o_v0,
  output logic [VERTEX_W-1:0]   o_v1,
  output logic [VERTEX_W-1:0]   o_v2,
  output logic [WORD_W-1:0]     o_sid
);

  logic [VERTEX_W-1:0] r_v0;
  logic [VERTEX_W-1:0] r_v1;
  logic [VERTEX_W-1:0] r_v2;
  logic [WORD_W-1:0]   r_sid;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_v0  <= '0;
      r_v1  <= '0;
      r_v2  <= '0;
      r_sid <= '0;
    end else if (i_wr_en) begin
      unique case (slot_vertex(i_word_idx))
        2'd0:    r_v0[slot_lsb(i_word_idx) +: WORD_W] <= i_wdata;
        2'd1:    r_v1[slot_lsb(i_word_idx) +: WORD_W] <= i_wdata;
        2'd2:    r_v2[slot_lsb(i_word_idx) +: WORD_W] <= i_wdata;
        default: r_sid <= i_wdata;
      endcase
    end
  end

  assign o_v0  = r_v0;
  assign o_v1  = r_v1;
  assign o_v2  = r_v2;
  assign o_sid = r_sid;

endmodule

// File: rtl/tri_mem_fetcher.sv
// Triangle record fetcher: reads one 10-word record per Mem_En and pulses Mem_Rdy.
// Optional TRI_FETCH_STATS_EN adds fetch_count / stall_cycles counters.
module tri_mem_fetcher
  import tri_fetch_pkg::*;
#(
  parameter int                NUM_TRIANGLE = 512,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                Mem_En,
  output logic                Mem_Rdy,
  output logic                Mem_NotValid,
  output logic [VERTEX_W-1:0] v0_out,
  output logic [VERTEX_W-1:0] v1_out,
  output logic [VERTEX_W-1:0] v2_out,
  output logic [WORD_W-1:0]   sid_out,
`ifdef TRI_FETCH_STATS_EN
  tri_mem_fetcher_if.master   mem,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_cycles
`else
  tri_mem_fetcher_if.master   mem
`endif
);

  localparam int               IDX_W    = $clog2(NUM_TRIANGLE) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRIANGLE);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [WORD_IDX_W-1:0] r_word;
  logic [WORD_IDX_W-1:0] w_word_nxt;
  logic                  w_asm_wr;
  logic                  w_asm_clr;
  logic [ADDR_W-1:0]     w_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_asm_wr    = 1'b0;
    w_asm_clr   = 1'b0;
    if (clear) begin
      w_idx_nxt  = '0;
      w_word_nxt = '0;
      w_asm_clr  = 1'b1;
      // A response landing in the clear cycle is already consumed, so nothing is left to drain.
      w_state_nxt = (r_state == ST_WAIT && !mem.mem_rvalid) ? ST_DRAIN : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (Mem_En) begin
            w_word_nxt = '0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = ST_DONE;
              w_asm_clr   = 1'b1;
            end else begin
              w_state_nxt = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem.mem_rvalid) begin
            w_asm_wr = 1'b1;
            if (r_word == SID_W) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_word_nxt  = r_word + 4'd1;
              w_state_nxt = ST_REQ;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          if (sid_out != '0) w_idx_nxt = r_idx + IDX_W'(1);
        end
        ST_DRAIN: begin
          if (mem.mem_rvalid) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Word address wraps modulo 2^ADDR_W.
  assign w_addr = BASE_ADDR
                + ADDR_W'(r_idx) * ADDR_W'(WORDS_PER_TRI)
                + ADDR_W'(r_word);

  assign mem.mem_rd   = (r_state == ST_REQ);
  assign mem.mem_addr = (r_state == ST_REQ) ? w_addr : '0;
  assign Mem_Rdy      = (r_state == ST_DONE);
  assign Mem_NotValid = (r_state != ST_IDLE);

  tri_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_asm_clr),
    .i_wr_en    (w_asm_wr),
    .i_word_idx (r_word),
    .i_wdata    (mem.mem_rdata),
    .o_v0       (v0_out),
    .o_v1       (v1_out),
    .o_v2       (v2_out),
    .o_sid      (sid_out)
  );

`ifdef TRI_FETCH_STATS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_cycles;
  logic        w_stall;

  assign w_stall = (r_state == ST_REQ  && !mem.mem_gnt)
                || (r_state == ST_WAIT && !mem.mem_rvalid);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_fetch_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (Mem_Rdy && r_fetch_count != '1)  r_fetch_count  <= r_fetch_count + 32'd1;
      if (w_stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule
